// File: rtl/ep_prbs_gen_check.sv
// PRBS7/15/23/31 word generator and self-synchronising checker for SerDes link debug.
// Checker locks on a clean run of words, then counts bit errors against a free-running predictor.
module ep_prbs_gen_check #(
    parameter int unsigned g_data_width       = 16,
    parameter int unsigned g_counter_width    = 32,
    parameter int unsigned g_lock_threshold   = 32,
    parameter int unsigned g_unlock_threshold = 4
) (
    input  logic                       clk_sys_i,
    input  logic                       rst_sys_i,
    input  logic [1:0]                 poly_sel_i,
    input  logic                       tx_en_i,
    input  logic                       tx_inject_i,
    output logic [g_data_width-1:0]    tx_data_o,
    output logic                       tx_valid_o,
    input  logic [g_data_width-1:0]    rx_data_i,
    input  logic                       rx_valid_i,
    input  logic                       check_en_i,
    input  logic                       clear_i,
    input  logic                       latch_i,
    output logic                       lock_o,
    output logic                       rx_err_o,
    output logic [g_counter_width-1:0] err_count_o,
    output logic                       err_sat_o
);

    localparam int unsigned W  = g_data_width;
    localparam int unsigned C  = g_counter_width;
    localparam int unsigned PW = $clog2(W + 1);
    localparam int unsigned GW = $clog2(g_lock_threshold + 1);
    localparam int unsigned BW = $clog2(g_unlock_threshold + 1);
    localparam int unsigned SW = ((C > PW) ? C : PW) + 1;
    localparam logic [SW-1:0] CntMax = {{(SW - C){1'b0}}, {C{1'b1}}};

    typedef enum logic [1:0] {StIdle, StSeek, StLocked} state_e;

    function automatic logic fb_bit(input logic [30:0] s, input logic [1:0] p);
        case (p)
            2'd0:    return s[6] ^ s[5];
            2'd1:    return s[14] ^ s[13];
            2'd2:    return s[22] ^ s[17];
            default: return s[30] ^ s[27];
        endcase
    endfunction

    // Next W bits of the sequence, first bit in the MSB.
    function automatic logic [W-1:0] prbs_word(input logic [30:0] s, input logic [1:0] p);
        logic [30:0]  st;
        logic [W-1:0] wd;
        st = s;
        wd = '0;
        for (int i = 0; i < W; i++) begin
            wd[W-1-i] = fb_bit(st, p);
            st        = {st[29:0], wd[W-1-i]};
        end
        return wd;
    endfunction

    function automatic logic [30:0] shift_in(input logic [30:0] s, input logic [W-1:0] wd);
        logic [30:0] st;
        st = s;
        for (int i = 0; i < W; i++) begin
            st = {st[29:0], wd[W-1-i]};
        end
        return st;
    endfunction

    logic [30:0]   lfsr_q;
    logic [1:0]    poly_q;
    logic          poly_chg;
    logic [W-1:0]  gen_word;

    assign poly_chg = (poly_sel_i != poly_q);
    assign gen_word = prbs_word(lfsr_q, poly_q);

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            lfsr_q     <= '1;
            poly_q     <= 2'd0;
            tx_data_o  <= '0;
            tx_valid_o <= 1'b0;
        end else if (poly_chg) begin
            lfsr_q     <= '1;
            poly_q     <= poly_sel_i;
            tx_data_o  <= '0;
            tx_valid_o <= 1'b0;
        end else if (tx_en_i) begin
            lfsr_q     <= shift_in(lfsr_q, gen_word);
            tx_data_o  <= gen_word ^ W'(tx_inject_i);
            tx_valid_o <= 1'b1;
        end else begin
            tx_data_o  <= '0;
            tx_valid_o <= 1'b0;
        end
    end

    state_e        state_q, state_d;
    logic [30:0]   hist_q, hist_d, hist_nxt;
    logic [30:0]   pred_q, pred_d;
    logic [GW-1:0] good_q, good_d;
    logic [BW-1:0] bad_q, bad_d;
    logic [C-1:0]  live_q, live_d;
    logic          sat_q, sat_d;
    logic [W-1:0]  hist_word, pred_word, diff;
    logic [PW-1:0] pc;
    logic          mismatch, err_pulse;
    logic [SW-1:0] sum;

    assign hist_word = prbs_word(hist_q, poly_q);
    assign pred_word = prbs_word(pred_q, poly_q);
    assign hist_nxt  = shift_in(hist_q, rx_data_i);
    assign diff      = rx_data_i ^ ((state_q == StLocked) ? pred_word : hist_word);
    assign mismatch  = |diff;

    always_comb begin
        pc = '0;
        for (int i = 0; i < W; i++) begin
            pc = pc + PW'(diff[i]);
        end
    end

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        pred_d    = pred_q;
        good_d    = good_q;
        bad_d     = bad_q;
        err_pulse = 1'b0;
        if (!check_en_i) begin
            state_d = StIdle;
        end else if (poly_chg || state_q == StIdle) begin
            state_d = StSeek;
            good_d  = '0;
        end else if (rx_valid_i) begin
            hist_d = hist_nxt;
            if (state_q == StSeek) begin
                if (mismatch) begin
                    good_d = '0;
                end else begin
                    good_d = good_q + GW'(1);
                    if (good_d == GW'(g_lock_threshold)) begin
                        // Predictor takes over from the history that just matched.
                        state_d = StLocked;
                        pred_d  = hist_nxt;
                        bad_d   = '0;
                    end
                end
            end else begin
                pred_d = shift_in(pred_q, pred_word);
                if (mismatch) begin
                    err_pulse = 1'b1;
                    bad_d     = bad_q + BW'(1);
                    if (bad_d == BW'(g_unlock_threshold)) begin
                        state_d = StSeek;
                        good_d  = '0;
                    end
                end else begin
                    bad_d = '0;
                end
            end
        end
    end

    assign sum = SW'(live_q) + SW'(pc);

    always_comb begin
        live_d = live_q;
        sat_d  = sat_q;
        if (clear_i) begin
            live_d = '0;
            sat_d  = 1'b0;
        end else if (err_pulse) begin
            if (sum > CntMax) begin
                live_d = '1;
                sat_d  = 1'b1;
            end else begin
                live_d = sum[C-1:0];
            end
        end
    end

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            state_q     <= StIdle;
            hist_q      <= '0;
            pred_q      <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            live_q      <= '0;
            sat_q       <= 1'b0;
            lock_o      <= 1'b0;
            rx_err_o    <= 1'b0;
            err_count_o <= '0;
            err_sat_o   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            pred_q    <= pred_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            live_q    <= live_d;
            sat_q     <= sat_d;
            lock_o    <= (state_d == StLocked);
            rx_err_o  <= err_pulse;
            err_sat_o <= sat_d;
            if (latch_i) begin
                err_count_o <= live_q;
            end
        end
    end

endmodule

// File: tb/tb_ep_prbs_gen_check.sv
// Directed bench: two instances (W=16/C=8 and W=20/C=32) with tx looped back to rx.
module tb_ep_prbs_gen_check;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance 0: W=16, C=8
    logic        rst0 = 1'b1, tx_en0 = 1'b0, inject0 = 1'b0, check_en0 = 1'b0;
    logic        clear0 = 1'b0, latch0 = 1'b0, force0 = 1'b0;
    logic [1:0]  poly0 = 2'd0;
    logic [15:0] tx_data0, rx_data0;
    logic        tx_valid0, lock0, rx_err0, err_sat0;
    logic [7:0]  err_count0;
    assign rx_data0 = force0 ? 16'hDEAD : tx_data0;

    // Instance 1: W=20, C=32
    logic        rst1 = 1'b1, tx_en1 = 1'b0, inject1 = 1'b0, check_en1 = 1'b0;
    logic        clear1 = 1'b0, latch1 = 1'b0;
    logic [1:0]  poly1 = 2'd0;
    logic [19:0] tx_data1;
    logic        tx_valid1, lock1, rx_err1, err_sat1;
    logic [31:0] err_count1;

    ep_prbs_gen_check #(.g_data_width(16), .g_counter_width(8)) dut0 (
        .clk_sys_i(clk), .rst_sys_i(rst0), .poly_sel_i(poly0), .tx_en_i(tx_en0),
        .tx_inject_i(inject0), .tx_data_o(tx_data0), .tx_valid_o(tx_valid0),
        .rx_data_i(rx_data0), .rx_valid_i(tx_valid0), .check_en_i(check_en0),
        .clear_i(clear0), .latch_i(latch0), .lock_o(lock0), .rx_err_o(rx_err0),
        .err_count_o(err_count0), .err_sat_o(err_sat0)
    );

    ep_prbs_gen_check #(.g_data_width(20)) dut1 (
        .clk_sys_i(clk), .rst_sys_i(rst1), .poly_sel_i(poly1), .tx_en_i(tx_en1),
        .tx_inject_i(inject1), .tx_data_o(tx_data1), .tx_valid_o(tx_valid1),
        .rx_data_i(tx_data1), .rx_valid_i(tx_valid1), .check_en_i(check_en1),
        .clear_i(clear1), .latch_i(latch1), .lock_o(lock1), .rx_err_o(rx_err1),
        .err_count_o(err_count1), .err_sat_o(err_sat1)
    );

    // Serial reference generators, one per instance
    logic [30:0] m0_st = '1, m1_st = '1;
    logic [1:0]  m0_poly = 2'd0, m1_poly = 2'd0;
    logic [63:0] m0_cur = '0, m1_cur = '0;
    int          forced_err = 0, forced_bad = 0;

    task automatic model_step(input int w, input logic rst, input logic en, input logic inj,
                              input logic [1:0] psel, inout logic [30:0] st,
                              inout logic [1:0] mp, inout logic [63:0] cur);
        logic fb;
        if (rst) begin
            st = '1; mp = 2'd0; cur = '0;
        end else if (psel != mp) begin
            st = '1; mp = psel; cur = '0;
        end else if (en) begin
            cur = '0;
            for (int i = 0; i < w; i++) begin
                case (mp)
                    2'd0:    fb = st[6] ^ st[5];
                    2'd1:    fb = st[14] ^ st[13];
                    2'd2:    fb = st[22] ^ st[17];
                    default: fb = st[30] ^ st[27];
                endcase
                st  = {st[29:0], fb};
                cur = {cur[62:0], fb};
            end
            cur[0] = cur[0] ^ inj;
        end else begin
            cur = '0;
        end
    endtask

    task automatic tick();
        logic [15:0] d;
        if (force0) begin
            d = 16'hDEAD ^ m0_cur[15:0];
            if (d != 16'h0) begin
                forced_err += $countones(d);
                forced_bad++;
            end
        end
        @(posedge clk);
        model_step(16, rst0, tx_en0, inject0, poly0, m0_st, m0_poly, m0_cur);
        model_step(20, rst1, tx_en1, inject1, poly1, m1_st, m1_poly, m1_cur);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick();
        checks += 6;
        if (tx_data0 !== 16'h0)  begin errors++; $display("FAIL reset_tx_data: got %h want 0", tx_data0); end
        if (tx_valid0 !== 1'b0)  begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid0); end
        if (lock0 !== 1'b0)      begin errors++; $display("FAIL reset_lock: got %b want 0", lock0); end
        if (rx_err0 !== 1'b0)    begin errors++; $display("FAIL reset_rx_err: got %b want 0", rx_err0); end
        if (err_count0 !== 8'h0) begin errors++; $display("FAIL reset_err_count: got %h want 0", err_count0); end
        if (err_sat0 !== 1'b0)   begin errors++; $display("FAIL reset_err_sat: got %b want 0", err_sat0); end
        rst0 = 1'b0;
        rst1 = 1'b0;
    endtask

    task automatic test_lock();
        int n;
        tx_en0 = 1'b1; check_en0 = 1'b1;
        tick(); n = 1;
        checks += 2;
        if (tx_data0 !== 16'h020C) begin errors++; $display("FAIL prbs7_word1: got %h want 020c", tx_data0); end
        tick(); n++;
        if (tx_data0 !== 16'h28F2) begin errors++; $display("FAIL prbs7_word2: got %h want 28f2", tx_data0); end
        while (!lock0 && n < 60) begin tick(); n++; end
        checks += 2;
        if (lock0 !== 1'b1) begin errors++; $display("FAIL lock_reached: got %b want 1", lock0); end
        if (n > 34) begin errors++; $display("FAIL lock_latency: got %0d words want <=34", n); end
        latch0 = 1'b1; tick(); latch0 = 1'b0;
        checks += 2;
        if (err_count0 !== 8'd0) begin errors++; $display("FAIL lock_count: got %0d want 0", err_count0); end
        if (err_sat0 !== 1'b0) begin errors++; $display("FAIL lock_sat: got %b want 0", err_sat0); end
    endtask

    task automatic test_inject();
        int pulses = 0;
        logic stayed = 1'b1;
        inject0 = 1'b1; tick(); inject0 = 1'b0;
        checks++;
        if (tx_data0 !== m0_cur[15:0]) begin
            errors++; $display("FAIL inject_word: got %h want %h", tx_data0, m0_cur[15:0]);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            pulses += int'(rx_err0);
            if (lock0 !== 1'b1) stayed = 1'b0;
        end
        latch0 = 1'b1; tick(); latch0 = 1'b0;
        checks += 3;
        if (pulses != 1) begin errors++; $display("FAIL inject_pulses: got %0d want 1", pulses); end
        if (stayed !== 1'b1) begin errors++; $display("FAIL inject_lock: got 0 want 1"); end
        if (err_count0 !== 8'd1) begin errors++; $display("FAIL inject_count: got %0d want 1", err_count0); end
    endtask

    task automatic test_force();
        int pulses = 0;
        int n = 0;
        logic lock_after3;
        forced_err = 0; forced_bad = 0;
        force0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            pulses += int'(rx_err0);
            if (i == 2) lock_after3 = lock0;
        end
        force0 = 1'b0;
        checks += 4;
        if (lock_after3 !== 1'b1) begin errors++; $display("FAIL force_lock3: got %b want 1", lock_after3); end
        if (lock0 !== 1'b0) begin errors++; $display("FAIL force_unlock4: got %b want 0", lock0); end
        if (pulses != forced_bad) begin errors++; $display("FAIL force_pulses: got %0d want %0d", pulses, forced_bad); end
        if (forced_bad != 4) begin errors++; $display("FAIL force_bad_words: got %0d want 4", forced_bad); end
        while (!lock0 && n < 40) begin tick(); n++; end
        latch0 = 1'b1; tick(); latch0 = 1'b0;
        checks += 3;
        if (lock0 !== 1'b1) begin errors++; $display("FAIL force_relock: got %b want 1", lock0); end
        if (n > 34) begin errors++; $display("FAIL force_relock_time: got %0d want <=34", n); end
        if (err_count0 !== 8'(1 + forced_err)) begin
            errors++; $display("FAIL force_count: got %0d want %0d", err_count0, 1 + forced_err);
        end
    endtask

    task automatic test_clear_latch();
        clear0 = 1'b1; tick(); clear0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            inject0 = 1'b1; tick(); inject0 = 1'b0; tick();
        end
        repeat (4) tick();
        clear0 = 1'b1; latch0 = 1'b1; tick(); clear0 = 1'b0; latch0 = 1'b0;
        checks += 3;
        if (err_count0 !== 8'd5) begin errors++; $display("FAIL clear_latch_snap: got %0d want 5", err_count0); end
        if (err_sat0 !== 1'b0) begin errors++; $display("FAIL clear_latch_sat: got %b want 0", err_sat0); end
        latch0 = 1'b1; tick(); latch0 = 1'b0;
        if (err_count0 !== 8'd0) begin errors++; $display("FAIL clear_latch_next: got %0d want 0", err_count0); end
    endtask

    task automatic test_saturate();
        int n = 0;
        poly0 = 2'd3; tick();
        while (!lock0 && n < 80) begin tick(); n++; end
        checks++;
        if (lock0 !== 1'b1) begin errors++; $display("FAIL prbs31_lock: got %b want 1", lock0); end
        for (int i = 0; i < 300; i++) begin
            inject0 = 1'b1; tick(); inject0 = 1'b0; tick();
        end
        repeat (4) tick();
        latch0 = 1'b1; tick(); latch0 = 1'b0;
        checks += 3;
        if (err_count0 !== 8'hFF) begin errors++; $display("FAIL sat_count: got %0d want 255", err_count0); end
        if (err_sat0 !== 1'b1) begin errors++; $display("FAIL sat_flag: got %b want 1", err_sat0); end
        if (lock0 !== 1'b1) begin errors++; $display("FAIL sat_lock: got %b want 1", lock0); end
        clear0 = 1'b1; tick(); clear0 = 1'b0;
        latch0 = 1'b1; tick(); latch0 = 1'b0;
        checks += 2;
        if (err_count0 !== 8'd0) begin errors++; $display("FAIL sat_clear_count: got %0d want 0", err_count0); end
        if (err_sat0 !== 1'b0) begin errors++; $display("FAIL sat_clear_flag: got %b want 0", err_sat0); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        poly1 = 2'd1; tx_en1 = 1'b1; check_en1 = 1'b1;
        while (!lock1 && n < 60) begin tick(); n++; end
        inject1 = 1'b1; tick(); inject1 = 1'b0;
        repeat (4) tick();
        latch1 = 1'b1; tick(); latch1 = 1'b0;
        checks += 2;
        if (lock1 !== 1'b1) begin errors++; $display("FAIL w20_lock: got %b want 1", lock1); end
        if (err_count1 !== 32'd1) begin errors++; $display("FAIL w20_count: got %0d want 1", err_count1); end
        rst1 = 1'b1; #1;
        checks += 6;
        if (tx_data1 !== 20'h0)   begin errors++; $display("FAIL mid_rst_tx_data: got %h want 0", tx_data1); end
        if (tx_valid1 !== 1'b0)   begin errors++; $display("FAIL mid_rst_tx_valid: got %b want 0", tx_valid1); end
        if (lock1 !== 1'b0)       begin errors++; $display("FAIL mid_rst_lock: got %b want 0", lock1); end
        if (rx_err1 !== 1'b0)     begin errors++; $display("FAIL mid_rst_rx_err: got %b want 0", rx_err1); end
        if (err_count1 !== 32'h0) begin errors++; $display("FAIL mid_rst_count: got %h want 0", err_count1); end
        if (err_sat1 !== 1'b0)    begin errors++; $display("FAIL mid_rst_sat: got %b want 0", err_sat1); end
        tick(); tick();
        rst1 = 1'b0;
        tick();
        checks += 3;
        if (tx_valid1 !== 1'b0) begin errors++; $display("FAIL reseed_valid: got %b want 0", tx_valid1); end
        tick();
        if (tx_data1 !== 20'h00020) begin errors++; $display("FAIL prbs15_word1: got %h want 00020", tx_data1); end
        if (tx_valid1 !== 1'b1) begin errors++; $display("FAIL prbs15_valid: got %b want 1", tx_valid1); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (tx_data1 !== m1_cur[19:0]) begin
                errors++; $display("FAIL prbs15_word%0d: got %h want %h", i + 2, tx_data1, m1_cur[19:0]);
            end
        end
        n = 0;
        while (!lock1 && n < 60) begin tick(); n++; end
        checks++;
        if (lock1 !== 1'b1) begin errors++; $display("FAIL w20_relock: got %b want 1", lock1); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_inject();
        test_force();
        test_clear_latch();
        test_saturate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
